// File: rtl/rtype_program_loader.sv
// Encodes add/sub/and/or commands into RV32I R-type words and writes them sequentially to instruction memory.
// Latency: a beat accepted at edge N appears on mem_we/mem_addr/mem_wdata in the following cycle.
// Backpressure: in_ready is registered, high only while loading with capacity left; beats without in_ready are held off.
module rtype_program_loader #(
    parameter int DEPTH    = 64,
    parameter int BASE_IDX = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic                       in_last,
    output logic                       mem_we,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    // Index and count need one extra state so "next index equals DEPTH" is representable.
    localparam int IW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] DEPTH_W    = IW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX_W = IW'(DEPTH - 1);
    localparam logic [IW-1:0] BASE_W     = IW'(BASE_IDX);
    localparam logic [6:0]    OPC_RTYPE  = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            rdy_q, rdy_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     enc;
    logic [6:0]      funct7;
    logic [2:0]      funct3;

    // Instruction encoding; op code matches the decoder's aluControl.
    always_comb begin
        funct7 = 7'b0000000;
        funct3 = 3'b000;
        case (in_op)
            2'b00:   begin funct7 = 7'b0000000; funct3 = 3'b000; end
            2'b01:   begin funct7 = 7'b0100000; funct3 = 3'b000; end
            2'b10:   begin funct7 = 7'b0000000; funct3 = 3'b111; end
            default: begin funct7 = 7'b0000000; funct3 = 3'b110; end
        endcase
        enc = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_RTYPE};
    end

    // Session FSM: next state, write port and ready computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = BASE_W;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid && rdy_q) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[AW-1:0];
                    wdata_d = enc;
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = cnt_q + IW'(1);
                    if (in_last) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX_W) begin
                        // Memory full without a terminating beat.
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Ready is registered from next state so it never depends on in_valid combinationally.
        rdy_d = (state_d == LOAD) && (idx_d != DEPTH_W);
    end

    // State and output registers; reset drops any pending write immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready  = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    // The DONE cycle is exactly the cycle carrying the final write.
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rtype_program_loader.sv
// Randomised bench for rtype_program_loader with a session-level reference model and write scoreboard.
// Model updates on the rising edge from the bench's own inputs; monitor compares on the falling edge.
// Backpressure: driver only advances a beat when it was presented while in_ready was high.
module tb_rtype_program_loader;
    localparam int DEPTH    = 8;
    localparam int BASE_IDX = 0;
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] count;
    logic          done;
    logic          overflow;

    rtype_program_loader #(.DEPTH(DEPTH), .BASE_IDX(BASE_IDX)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Straight from the R-type field table.
    function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        logic [6:0] f7;
        logic [2:0] f3;
        case (op)
            2'd0: begin f7 = 7'h00; f3 = 3'd0; end
            2'd1: begin f7 = 7'h20; f3 = 3'd0; end
            2'd2: begin f7 = 7'h00; f3 = 3'd7; end
            default: begin f7 = 7'h00; f3 = 3'd6; end
        endcase
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    // Reference model: session open/closing flags, next index, count, sticky overflow.
    bit          m_open = 0;
    bit          m_closing = 0;
    int          m_idx = 0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    bit          exp_we = 0;
    bit          exp_done = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_open <= 0; m_closing <= 0; m_idx <= 0; m_cnt <= 0; m_ovf <= 0;
            exp_we <= 0; exp_done <= 0;
            exp_addr_q.delete();
            exp_data_q.delete();
        end else begin
            exp_we   <= 0;
            exp_done <= 0;
            if (m_closing) begin
                m_closing <= 0;
            end else if (!m_open) begin
                if (start) begin
                    m_open <= 1; m_idx <= BASE_IDX; m_cnt <= 0; m_ovf <= 0;
                end
            end else if (in_valid) begin
                exp_addr_q.push_back(32'(m_idx));
                exp_data_q.push_back(encode(in_op, in_rd, in_rs1, in_rs2));
                exp_we <= 1;
                m_idx  <= m_idx + 1;
                m_cnt  <= m_cnt + 1;
                if (in_last || (m_idx + 1 == DEPTH)) begin
                    m_open    <= 0;
                    m_closing <= 1;
                    exp_done  <= 1;
                    if (!in_last) m_ovf <= 1;
                end
            end
        end
    end

    // Write log for directed checks on known instruction words.
    logic [31:0] wlog_data[$];
    logic [31:0] wlog_addr[$];

    // Monitor: every falling edge compare all outputs against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_open));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("done", 32'(done), 32'(exp_done));
        chk("count", 32'(count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mem_we) begin
            wlog_data.push_back(mem_wdata);
            wlog_addr.push_back(32'(mem_addr));
            if (exp_data_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                chk("mem_addr", 32'(mem_addr), exp_addr_q.pop_front());
                chk("mem_wdata", mem_wdata, exp_data_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [4:0] rd, rs1, rs2;
        logic       last;
    } beat_t;
    beat_t beat_q[$];

    task automatic add_beat(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic last);
        beat_t b;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.last = last;
        beat_q.push_back(b);
    endtask

    task automatic add_random(input int n, input bit with_last);
        for (int i = 0; i < n; i++)
            add_beat(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                     with_last && (i == n - 1));
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input int pv, input int ps, input int maxc);
        int  cyc = 0;
        bit  acc;
        while (beat_q.size() > 0 && cyc < maxc) begin
            in_valid = ($urandom_range(0, 99) < pv);
            start    = ($urandom_range(0, 99) < ps);
            in_op = beat_q[0].op; in_rd = beat_q[0].rd; in_rs1 = beat_q[0].rs1;
            in_rs2 = beat_q[0].rs2; in_last = beat_q[0].last;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) void'(beat_q.pop_front());
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0; in_last = 1'b0;
        beat_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);

        // Reset mid-session after three beats.
        pulse_start();
        add_random(6, 1'b1);
        run(100, 0, 3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // Single add, known encoding.
        wlog_data.delete(); wlog_addr.delete();
        pulse_start();
        add_beat(2'd0, 5'd3, 5'd1, 5'd2, 1'b1);
        run(100, 0, 20);
        idle(3);
        chk("t2_nwrites", 32'(wlog_data.size()), 32'd1);
        if (wlog_data.size() == 1) begin
            chk("t2_wdata", wlog_data[0], 32'h002081B3);
            chk("t2_addr", wlog_addr[0], 32'd0);
        end
        chk("t2_count", 32'(count), 32'd1);

        // sub / and / or back-to-back.
        wlog_data.delete(); wlog_addr.delete();
        pulse_start();
        add_beat(2'd1, 5'd5, 5'd6, 5'd7, 1'b0);
        add_beat(2'd2, 5'd8, 5'd9, 5'd10, 1'b0);
        add_beat(2'd3, 5'd11, 5'd12, 5'd13, 1'b1);
        run(100, 0, 20);
        idle(3);
        chk("t3_nwrites", 32'(wlog_data.size()), 32'd3);
        if (wlog_data.size() == 3) begin
            chk("t3_w0", wlog_data[0], 32'h407302B3);
            chk("t3_w1", wlog_data[1], 32'h00A4F433);
            chk("t3_w2", wlog_data[2], 32'h00D665B3);
            chk("t3_a2", wlog_addr[2], 32'd2);
        end
        chk("t3_count", 32'(count), 32'd3);

        // Overflow: more beats than capacity, no last.
        wlog_data.delete(); wlog_addr.delete();
        pulse_start();
        add_random(DEPTH + 2, 1'b0);
        run(100, 0, DEPTH + 8);
        idle(2);
        chk("t4_nwrites", 32'(wlog_data.size()), 32'(DEPTH));
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_count", 32'(count), 32'(DEPTH));

        // in_valid high in IDLE before start: nothing written.
        wlog_data.delete(); wlog_addr.delete();
        in_valid = 1'b1; in_op = 2'd2; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3; in_last = 1'b1;
        idle(4);
        chk("t6_idle_nowrite", 32'(wlog_data.size()), 32'd0);
        pulse_start();
        add_beat(2'd2, 5'd1, 5'd2, 5'd3, 1'b1);
        run(100, 0, 20);
        idle(3);
        chk("t6_nwrites", 32'(wlog_data.size()), 32'd1);
        if (wlog_addr.size() > 0) chk("t6_addr", wlog_addr[0], 32'(BASE_IDX));

        // Random valid, stray start pulses during loading.
        for (int s = 0; s < 12; s++) begin
            wlog_data.delete(); wlog_addr.delete();
            pulse_start();
            add_random($urandom_range(1, DEPTH), 1'b1);
            run(60, 20, 200);
            idle(3);
        end
        // Random session that runs out of room.
        pulse_start();
        add_random(DEPTH + 3, 1'b0);
        run(50, 0, 200);
        idle(3);

        chk("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
